ap_line_sequencer: RTL and testbench
====================================

Name: ap_line_sequencer

Overview:
- Command-side initiator for the data-pointer line (AP counter + data RAM + data counter).
- Takes one decoded Brainfuck-style instruction with a repeat count from the instruction pipeline.
- Drives the ApCountAck, DataCountAck, DataWriteAck and CounterReverse request lines, paces each step on the line's Ready, and returns completion, output data and a zero flag to the executor.

Parameters:
- DATA_W, 10, width of the cell data bus (matches the line's DataIn/DataOut).
- REP_W, 4, width of the repeat count.
- HOLDOFF, 2, Clk cycles after a request pulse during which Ready is ignored.
- TIMEOUT, 255, max Clk cycles spent waiting for Ready per step before Error.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  synchronous active-low reset
- InstrValid  in  1  instruction offered
- InstrReady  out  1  sequencer can accept an instruction
- Opcode  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 IN, 6 OUT, 7 ZTEST
- Repeat  in  REP_W  step count; 0 is treated as 1
- IoDataIn  in  DATA_W  value written to the cell by IN
- LineReady  in  1  Ready from the data-pointer line
- LineDataOut  in  DATA_W  DataOut from the data-pointer line
- ApCountAck  out  1  AP step request
- DataCountAck  out  1  data step request
- DataWriteAck  out  1  data write request
- CounterReverse  out  1  count direction (1 = down/left)
- LineDataIn  out  DATA_W  data presented to the line's DataIn
- Done  out  1  one-cycle pulse when the instruction completes
- OutValid  out  1  one-cycle pulse, OutData valid (OUT only)
- OutData  out  DATA_W  captured cell value
- Zero  out  1  last ZTEST/OUT result was zero
- Error  out  1  sticky flag, set on Ready timeout

Behaviour:
- Clocking and reset:
  - All state changes on the Clk rising edge.
  - While Rst_n = 0 at an edge: state IDLE; all request outputs, Done, OutValid and Error are 0; OutData and LineDataIn are 0; Zero is 0; InstrReady is 0 during reset and 1 in the first IDLE cycle after it.
  - A reset during any state aborts the instruction. No Done is produced and no request is re-issued.
- Accept:
  - InstrReady = 1 only in IDLE.
  - An instruction is accepted on an edge with InstrValid & InstrReady.
  - On accept, latch Opcode, IoDataIn, and step count N = (Repeat == 0) ? 1 : Repeat.
  - NOP: go directly to DONE (Done pulses 1 cycle after accept, no request driven).
- Request mapping (one step):
  - INC: DataCountAck, Rev = 0.
  - DEC: DataCountAck, Rev = 1.
  - RIGHT: ApCountAck, Rev = 0.
  - LEFT: ApCountAck, Rev = 1.
  - IN: DataWriteAck with LineDataIn = latched IoDataIn; N forced to 1.
  - OUT / ZTEST: no request; N forced to 1; the step is a Ready wait followed by a capture.
- CounterReverse is driven from accept until DONE and is held stable across all steps. It is 0 in IDLE.
- State machine IDLE -> ISSUE -> HOLDOFF -> WAIT -> (ISSUE | CAPTURE | DONE) -> IDLE:
  - ISSUE: the mapped request is 1 for exactly one Clk cycle. Exactly one request line is high at any time.
  - HOLDOFF: HOLDOFF cycles, LineReady ignored.
  - WAIT: leave on the first cycle LineReady = 1.
    - If remaining steps > 0, decrement and go to ISSUE.
    - Otherwise go to CAPTURE for OUT/ZTEST, else DONE.
  - WAIT timeout: after TIMEOUT cycles in WAIT without LineReady, set Error and go to DONE.
  - OUT/ZTEST: skip ISSUE/HOLDOFF and wait in WAIT for LineReady before CAPTURE.
  - CAPTURE: OutData <= LineDataOut; Zero <= (LineDataOut == 0); OutValid pulses for OUT only.
  - DONE: Done = 1 for one cycle, then IDLE.
- Latency (LineReady held high):
  - Per step: 1 + HOLDOFF + 1 cycles.
  - INC with Repeat = 3 and HOLDOFF = 2: Done at cycle 13 after accept.
- Error is sticky until reset. Instructions are still accepted and executed while Error = 1.
- Zero and OutData hold their value until the next CAPTURE.
- Repeat counter width is REP_W; the maximum repeat is 2^REP_W - 1; there is no wrap.

Test Plan:
- Reset mid-WAIT of an INC with Repeat = 5: assert Rst_n = 0 for 1 cycle. Required: all acks 0, no Done, InstrReady = 1 the cycle after release, Error = 0.
- INC with Repeat = 3, LineReady tied 1, HOLDOFF = 2: exactly 3 single-cycle DataCountAck pulses 4 cycles apart, CounterReverse = 0 throughout, Done 13 cycles after accept.
- LEFT with Repeat = 0: exactly 1 ApCountAck pulse with CounterReverse = 1, then Done. LineReady low for 10 cycles in WAIT extends the Done time by 10.
- IN with IoDataIn = 0x2A5: one DataWriteAck pulse with LineDataIn = 0x2A5, then Done. A following OUT with LineDataOut = 0x2A5 gives OutData = 0x2A5, OutValid pulse, Zero = 0.
- ZTEST with LineDataOut = 0: Zero = 1, no OutValid, no request line asserted. InstrValid held high back-to-back is accepted only in IDLE.
- RIGHT with LineReady stuck 0, TIMEOUT = 255: Error = 1 after 255 WAIT cycles, then Done. Error stays 1 through a subsequent NOP.

Source files
------------

// File: rtl/ap_line_sequencer.sv
// ap_line_sequencer
// Command-side initiator for the data-pointer line (AP counter, data RAM and
// data counter). It accepts one decoded instruction with a repeat count. Each
// step issues a one-cycle request, ignores Ready for a short hold-off, and then
// waits for Ready. The sequencer reports completion, captured cell data and a
// zero flag. A sticky error is raised if Ready does not arrive in time.
module ap_line_sequencer #(
   parameter int DATA_W  = 10,
   parameter int REP_W   = 4,
   parameter int HOLDOFF = 2,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   input  logic [2:0]        i_opcode,
   input  logic [REP_W-1:0]  i_repeat,
   input  logic [DATA_W-1:0] i_io_data_in,
   input  logic              i_line_ready,
   input  logic [DATA_W-1:0] i_line_data_out,
   output logic              o_ap_count_ack,
   output logic              o_data_count_ack,
   output logic              o_data_write_ack,
   output logic              o_counter_reverse,
   output logic [DATA_W-1:0] o_line_data_in,
   output logic              o_done,
   output logic              o_out_valid,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_zero,
   output logic              o_error
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_INC   = 3'd1;
   localparam logic [2:0] OP_DEC   = 3'd2;
   localparam logic [2:0] OP_RIGHT = 3'd3;
   localparam logic [2:0] OP_LEFT  = 3'd4;
   localparam logic [2:0] OP_IN    = 3'd5;
   localparam logic [2:0] OP_OUT   = 3'd6;
   localparam logic [2:0] OP_ZTEST = 3'd7;

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_HOLD,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [2:0]        r_op;
   logic [REP_W-1:0]  r_remain;
   logic [HO_W-1:0]   r_hold_cnt;
   logic [TO_W-1:0]   r_wait_cnt;
   logic              r_instr_ready;
   logic              r_ap_ack;
   logic              r_dc_ack;
   logic              r_dw_ack;
   logic              r_rev;
   logic [DATA_W-1:0] r_line_data_in;
   logic              r_done;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_zero;
   logic              r_error;

   // The opcode that selects the next request line. A fresh instruction is
   // still on the input in IDLE. Later steps use the latched copy.
   logic [2:0] w_sel_op;
   logic       w_is_ap;
   logic       w_is_dc;
   logic       w_is_dw;
   logic       w_is_read;

   assign w_sel_op  = (r_state == S_IDLE) ? i_opcode : r_op;
   assign w_is_ap   = (w_sel_op == OP_RIGHT) || (w_sel_op == OP_LEFT);
   assign w_is_dc   = (w_sel_op == OP_INC)   || (w_sel_op == OP_DEC);
   assign w_is_dw   = (w_sel_op == OP_IN);
   assign w_is_read = (w_sel_op == OP_OUT)   || (w_sel_op == OP_ZTEST);

   // Sequencer FSM. All outputs are registered. Request pulses and Done are
   // set on the edge that enters ISSUE or DONE. They clear by default on the
   // following edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= S_IDLE;
         r_op           <= OP_NOP;
         r_remain       <= '0;
         r_hold_cnt     <= '0;
         r_wait_cnt     <= '0;
         r_instr_ready  <= 1'b0;
         r_ap_ack       <= 1'b0;
         r_dc_ack       <= 1'b0;
         r_dw_ack       <= 1'b0;
         r_rev          <= 1'b0;
         r_line_data_in <= '0;
         r_done         <= 1'b0;
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_zero         <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_ap_ack    <= 1'b0;
         r_dc_ack    <= 1'b0;
         r_dw_ack    <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_instr_valid && r_instr_ready) begin
                  r_op          <= i_opcode;
                  r_instr_ready <= 1'b0;
                  r_rev         <= (i_opcode == OP_DEC) || (i_opcode == OP_LEFT);
                  if (i_opcode == OP_IN) begin
                     r_line_data_in <= i_io_data_in;
                  end
                  // Only the counting opcodes repeat. Every other opcode runs one step.
                  if ((w_is_ap || w_is_dc) && (i_repeat != '0)) begin
                     r_remain <= i_repeat - REP_W'(1);
                  end else begin
                     r_remain <= '0;
                  end
                  if (i_opcode == OP_NOP) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (w_is_read) begin
                     r_state    <= S_WAIT;
                     r_wait_cnt <= '0;
                  end else begin
                     r_state  <= S_ISSUE;
                     r_ap_ack <= w_is_ap;
                     r_dc_ack <= w_is_dc;
                     r_dw_ack <= w_is_dw;
                  end
               end else begin
                  r_instr_ready <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (HOLDOFF == 0) begin
                  r_state    <= S_WAIT;
                  r_wait_cnt <= '0;
               end else begin
                  r_state    <= S_HOLD;
                  r_hold_cnt <= '0;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == HO_W'(HOLDOFF - 1)) begin
                  r_state    <= S_WAIT;
                  r_wait_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HO_W'(1);
               end
            end
            S_WAIT: begin
               if (i_line_ready) begin
                  if (r_remain != '0) begin
                     r_remain <= r_remain - REP_W'(1);
                     r_state  <= S_ISSUE;
                     r_ap_ack <= w_is_ap;
                     r_dc_ack <= w_is_dc;
                     r_dw_ack <= w_is_dw;
                  end else if (w_is_read) begin
                     r_state <= S_CAPTURE;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end else if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
                  // Abandon the remaining steps. Error stays set until reset.
                  r_error <= 1'b1;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + TO_W'(1);
               end
            end
            S_CAPTURE: begin
               r_out_data  <= i_line_data_out;
               r_zero      <= (i_line_data_out == '0);
               r_out_valid <= (r_op == OP_OUT);
               r_state     <= S_DONE;
               r_done      <= 1'b1;
            end
            S_DONE: begin
               r_state       <= S_IDLE;
               r_instr_ready <= 1'b1;
               r_rev         <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_instr_ready     = r_instr_ready;
   assign o_ap_count_ack    = r_ap_ack;
   assign o_data_count_ack  = r_dc_ack;
   assign o_data_write_ack  = r_dw_ack;
   assign o_counter_reverse = r_rev;
   assign o_line_data_in    = r_line_data_in;
   assign o_done            = r_done;
   assign o_out_valid       = r_out_valid;
   assign o_out_data        = r_out_data;
   assign o_zero            = r_zero;
   assign o_error           = r_error;

endmodule

// File: tb/tb_ap_line_sequencer.sv
// tb_ap_line_sequencer
// Directed and random instructions for ap_line_sequencer. Expected timing
// comes from a step-level model. Each step issues at edge t, Ready is ignored
// for HOLDOFF cycles, and the step then completes on the first Ready seen in
// WAIT. Edge numbers are counted from the accept edge, which is edge 0.
module tb_ap_line_sequencer;

   localparam int DATA_W  = 10;
   localparam int REP_W   = 4;
   localparam int HOLDOFF = 2;
   localparam int TIMEOUT = 255;
   localparam int MAXE    = 4096;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        opcode;
   logic [REP_W-1:0]  repeat_cnt;
   logic [DATA_W-1:0] io_data_in;
   logic              line_ready;
   logic [DATA_W-1:0] line_data_out;
   logic              ap_ack;
   logic              dc_ack;
   logic              dw_ack;
   logic              rev;
   logic [DATA_W-1:0] line_data_in;
   logic              done;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              zero;
   logic              error;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Model state that persists across instructions.
   int exp_out_data = 0;
   int exp_zero     = 0;
   int exp_error    = 0;

   // Ready value that the bench drives before edge k, and the edges on which
   // the model expects a request pulse.
   bit rdy [0:MAXE-1];
   bit iss [0:MAXE-1];

   always #5 clk = ~clk;

   ap_line_sequencer #(
      .DATA_W (DATA_W),
      .REP_W  (REP_W),
      .HOLDOFF(HOLDOFF),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_instr_valid    (instr_valid),
      .o_instr_ready    (instr_ready),
      .i_opcode         (opcode),
      .i_repeat         (repeat_cnt),
      .i_io_data_in     (io_data_in),
      .i_line_ready     (line_ready),
      .i_line_data_out  (line_data_out),
      .o_ap_count_ack   (ap_ack),
      .o_data_count_ack (dc_ack),
      .o_data_write_ack (dw_ack),
      .o_counter_reverse(rev),
      .o_line_data_in   (line_data_in),
      .o_done           (done),
      .o_out_valid      (out_valid),
      .o_out_data       (out_data),
      .o_zero           (zero),
      .o_error          (error)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Ready patterns: 0 = always high, 1 = random (75% high), 2 = never high,
   // 3 = low on edges 1..13 and high afterwards.
   task automatic fill_ready(input int mode);
      for (int i = 0; i < MAXE; i++) begin
         case (mode)
            0:       rdy[i] = 1'b1;
            1:       rdy[i] = ($urandom_range(0, 3) != 0);
            2:       rdy[i] = 1'b0;
            default: rdy[i] = !(i >= 1 && i <= 13);
         endcase
         iss[i] = 1'b0;
      end
   endtask

   // First edge in (from, from+TIMEOUT] with Ready high, or -1 on timeout.
   function automatic int find_ready(input int from);
      for (int e = from + 1; e <= from + TIMEOUT && e < MAXE; e++) begin
         if (rdy[e]) return e;
      end
      return -1;
   endfunction

   task automatic run_instr(input logic [2:0] op, input logic [REP_W-1:0] rep,
                            input logic [DATA_W-1:0] iodat, input logic [DATA_W-1:0] ldo,
                            input int mode, output int done_obs);
      int n, done_exp, line, t, w, e, k_last;
      int ack_bad, rev_bad, rdy_bad, ov_cnt, ov_bad, ldi_bad, done_cnt;
      bit to, exp_rev;
      logic [2:0] exp_vec, obs_vec;

      fill_ready(mode);
      to       = 1'b0;
      done_exp = 0;
      exp_rev  = (op == 3'd2) || (op == 3'd4);
      line     = (op == 3'd3 || op == 3'd4) ? 0 : ((op == 3'd1 || op == 3'd2) ? 1 : 2);
      n        = (op >= 3'd1 && op <= 3'd4) ? ((rep == 0) ? 1 : int'(rep)) : 1;

      if (op == 3'd0) begin
         done_exp = 0;
      end else if (op == 3'd6 || op == 3'd7) begin
         e = find_ready(0);
         if (e < 0) begin
            to = 1'b1;
            done_exp = TIMEOUT;
         end else begin
            done_exp = e + 1;
         end
      end else begin
         t = 0;
         for (int s = 0; s < n; s++) begin
            iss[t] = 1'b1;
            w = t + 1 + HOLDOFF;
            e = find_ready(w);
            if (e < 0) begin
               to = 1'b1;
               done_exp = w + TIMEOUT;
               break;
            end
            if (s == n - 1) done_exp = e;
            else t = e;
         end
      end

      // Present the instruction and wait until the sequencer can take it.
      instr_valid   = 1'b1;
      opcode        = op;
      repeat_cnt    = rep;
      io_data_in    = iodat;
      line_data_out = ldo;
      line_ready    = rdy[0];
      for (int wt = 0; wt < 64 && !instr_ready; wt++) begin
         @(posedge clk);
         #1;
      end
      if (!instr_ready) begin
         check("instr_ready_wait", 0, 1);
         done_obs = -1;
         return;
      end

      ack_bad = 0; rev_bad = 0; rdy_bad = 0; ov_cnt = 0; ov_bad = 0;
      ldi_bad = 0; done_cnt = 0; done_obs = -1;
      k_last = (done_exp + 1 < MAXE - 1) ? done_exp + 1 : MAXE - 2;
      for (int k = 0; k <= k_last; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            // The instruction must be latched on accept, so scramble the inputs.
            io_data_in = ~iodat;
            repeat_cnt = REP_W'($urandom);
         end
         exp_vec = 3'b000;
         if (iss[k]) exp_vec[line] = 1'b1;
         obs_vec = {dw_ack, dc_ack, ap_ack};
         if (obs_vec != exp_vec) ack_bad++;
         if (dw_ack && line_data_in != iodat) ldi_bad++;
         if (rev != ((k <= done_exp) ? exp_rev : 1'b0)) rev_bad++;
         if (instr_ready != (k == done_exp + 1)) rdy_bad++;
         if (done) begin
            done_cnt++;
            if (done_obs < 0) done_obs = k;
         end
         if (out_valid) begin
            ov_cnt++;
            if (k != done_exp) ov_bad++;
         end
         line_ready = rdy[k + 1];
      end

      if (!to && (op == 3'd6 || op == 3'd7)) begin
         exp_out_data = int'(ldo);
         exp_zero     = (ldo == 0) ? 1 : 0;
      end
      if (to) exp_error = 1;

      check("ack_pattern", ack_bad, 0);
      check("line_data_in", ldi_bad, 0);
      check("counter_reverse", rev_bad, 0);
      check("instr_ready", rdy_bad, 0);
      check("done_at", done_obs, done_exp);
      check("done_count", done_cnt, 1);
      check("out_valid_count", ov_cnt, (op == 3'd6 && !to) ? 1 : 0);
      check("out_valid_time", ov_bad, 0);
      check("out_data", int'(out_data), exp_out_data);
      check("zero", int'(zero), exp_zero);
      check("error", int'(error), exp_error);
      $display("txn %0d: op=%0d rep=%0d mode=%0d done_at=%0d expected_at=%0d",
               txn, op, rep, mode, done_obs, done_exp);
      txn++;
   endtask

   initial begin
      int d0, d1, gap;
      logic [2:0]        rop;
      logic [REP_W-1:0]  rrep;
      logic [DATA_W-1:0] rio, rldo;
      int rmode;

      rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0; repeat_cnt = '0;
      io_data_in = '0; line_ready = 1'b0; line_data_out = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_instr_ready", int'(instr_ready), 0);
      check("rst_acks", int'({dw_ack, dc_ack, ap_ack}), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_zero", int'(zero), 0);
      check("rst_line_data_in", int'(line_data_in), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_ready", int'(instr_ready), 1);

      // INC x3 with Ready high: Done appears in the 13th cycle after accept,
      // which is after the 12th edge following the accept edge.
      run_instr(3'd1, 4'd3, 10'h000, 10'h000, 0, d0);
      check("inc3_done_edge", d0, 12);
      // LEFT with Repeat 0 runs one step. A 10-cycle Ready stall in WAIT adds 10.
      run_instr(3'd4, 4'd0, 10'h000, 10'h000, 0, d0);
      run_instr(3'd4, 4'd0, 10'h000, 10'h000, 3, d1);
      gap = d1 - d0;
      check("left_stall_extend", gap, 10);
      run_instr(3'd5, 4'd9, 10'h2A5, 10'h000, 0, d0);
      run_instr(3'd6, 4'd0, 10'h000, 10'h2A5, 0, d0);
      run_instr(3'd7, 4'd0, 10'h000, 10'h000, 1, d0);
      run_instr(3'd3, 4'd7, 10'h000, 10'h000, 2, d0);
      run_instr(3'd0, 4'd0, 10'h000, 10'h000, 0, d0);
      run_instr(3'd2, 4'd15, 10'h000, 10'h000, 1, d0);

      // Reset while the first INC step is waiting. Edge 3 enters WAIT, and
      // the reset edge lands where the second pulse would have been issued.
      opcode = 3'd1; repeat_cnt = 4'd5; line_ready = 1'b1; instr_valid = 1'b1;
      for (int wt = 0; wt < 64 && !instr_ready; wt++) begin
         @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);
      #1;
      instr_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_acks", int'({dw_ack, dc_ack, ap_ack}), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_error", int'(error), 0);
      check("midrst_instr_ready", int'(instr_ready), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_release_ready", int'(instr_ready), 1);
      d0 = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || ap_ack || dc_ack || dw_ack) d0++;
         @(posedge clk);
         #1;
      end
      check("midrst_quiet", d0, 0);
      exp_error = 0; exp_out_data = 0; exp_zero = 0;
      $display("txn %0d: reset during INC wait", txn);
      txn++;

      // Random instructions, issued back to back.
      for (int i = 0; i < 60; i++) begin
         rop   = 3'($urandom_range(0, 7));
         rrep  = REP_W'($urandom);
         rio   = DATA_W'($urandom);
         rldo  = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
         rmode = ($urandom_range(0, 29) == 0) ? 2 : ($urandom_range(0, 3) == 0 ? 0 : 1);
         run_instr(rop, rrep, rio, rldo, rmode, d0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
